// File: rtl/cam_pkg.sv
// Shared codes for the CAM loader: FSM states, command field encodings and
// the array input_mode codes.
package cam_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RD_ADDR = 3'd2,
    RD_WAIT = 3'd3,
    RD_CAP  = 3'd4,
    OUT     = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic OP_LOAD   = 1'b0;
  localparam logic OP_UNLOAD = 1'b1;
  localparam logic DIR_ROW   = 1'b0;
  localparam logic DIR_COL   = 1'b1;

  localparam logic [2:0] MODE_NONE    = 3'd0;
  localparam logic [2:0] ROWXROW_CODE = 3'd1;
  localparam logic [2:0] COLXCOL_CODE = 3'd2;

  function automatic logic [2:0] mode_for(input logic       dir,
                                          input logic [2:0] row_code,
                                          input logic [2:0] col_code);
    if (dir == DIR_COL) begin
      return col_code;
    end else begin
      return row_code;
    end
  endfunction

endpackage

// File: rtl/cam_loader_if.sv
// Host-side command, load-stream and unload-stream bundle of the CAM loader.
interface cam_loader_if #(
  parameter int DATA_DEPTH     = 16,
  parameter int ADDR_WIDTH_CAM = 8
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_op;
  logic                      cmd_dir;
  logic [ADDR_WIDTH_CAM-1:0] cmd_base;
  logic [ADDR_WIDTH_CAM:0]   cmd_count;
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_DEPTH-1:0]     in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_DEPTH-1:0]     out_data;
  logic                      busy;
  logic                      done;

  modport master (
    output cmd_valid, cmd_op, cmd_dir, cmd_base, cmd_count, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dir, cmd_base, cmd_count, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/cam_addr_ctr.sv
// Row/column index counter: loads a base, steps by one and wraps to zero once
// it reaches the supplied limit (or anything beyond it).
module cam_addr_ctr #(
  parameter int ADDR_WIDTH_CAM = 8
) (
  input  logic                      clk,
  input  logic                      rstIn,
  input  logic                      i_load,
  input  logic [ADDR_WIDTH_CAM-1:0] i_load_val,
  input  logic                      i_inc,
  input  logic [ADDR_WIDTH_CAM-1:0] i_limit,
  output logic [ADDR_WIDTH_CAM-1:0] o_idx
);
  localparam logic [ADDR_WIDTH_CAM-1:0] IDX_ZERO = {ADDR_WIDTH_CAM{1'b0}};
  localparam logic [ADDR_WIDTH_CAM-1:0] IDX_ONE  = {{(ADDR_WIDTH_CAM-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH_CAM-1:0] r_idx;

  // Index register: load has priority over increment.
  always_ff @(posedge clk) begin
    if (rstIn) begin
      r_idx <= IDX_ZERO;
    end else if (i_load) begin
      r_idx <= i_load_val;
    end else if (i_inc) begin
      r_idx <= (r_idx >= i_limit) ? IDX_ZERO : (r_idx + IDX_ONE);
    end else begin
      r_idx <= r_idx;
    end
  end

  assign o_idx = r_idx;
endmodule

// File: rtl/cam_loader.sv
// Sequences word-wise LOAD (write) and UNLOAD (read) transfers between a host
// stream interface and a transposable CAM array, row- or column-oriented.
module cam_loader
  import cam_pkg::*;
#(
  parameter int         DATA_WIDTH     = 8,
  parameter int         DATA_DEPTH     = 16,
  parameter int         ADDR_WIDTH_CAM = 8,
  parameter logic [2:0] RowxRow        = ROWXROW_CODE,
  parameter logic [2:0] ColxCol        = COLXCOL_CODE
) (
  input  logic                      clk,
  input  logic                      rstIn,
  cam_loader_if.slave               bus,
  input  logic [DATA_WIDTH-1:0]     ext_Mask,
  output logic [DATA_WIDTH-1:0]     cam_Mask,
  output logic [DATA_WIDTH-1:0]     cam_Ip_row,
  output logic [DATA_DEPTH-1:0]     cam_Ip_col,
  output logic [ADDR_WIDTH_CAM-1:0] cam_addr_input_Row,
  output logic [ADDR_WIDTH_CAM-1:0] cam_addr_input_Col,
  output logic [ADDR_WIDTH_CAM-1:0] cam_addr_output_Row,
  output logic [ADDR_WIDTH_CAM-1:0] cam_addr_output_Col,
  output logic [2:0]                cam_input_mode,
  output logic                      cam_wr_n,
  input  logic [DATA_WIDTH-1:0]     cam_Q_out_row,
  input  logic [DATA_DEPTH-1:0]     cam_Q_out_col
);
  localparam logic [ADDR_WIDTH_CAM:0]   ZERO_CNT = {(ADDR_WIDTH_CAM+1){1'b0}};
  localparam logic [ADDR_WIDTH_CAM:0]   ONE_CNT  = {{ADDR_WIDTH_CAM{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH_CAM-1:0] ZERO_ADR = {ADDR_WIDTH_CAM{1'b0}};
  localparam logic [ADDR_WIDTH_CAM-1:0] LIM_ROW  = ADDR_WIDTH_CAM'(DATA_DEPTH - 1);
  localparam logic [ADDR_WIDTH_CAM-1:0] LIM_COL  = ADDR_WIDTH_CAM'(DATA_WIDTH - 1);

  state_t r_state, w_state_nxt;
  logic   r_op, r_dir;
  logic   [ADDR_WIDTH_CAM:0]   r_rem, w_rem_nxt;
  logic   [ADDR_WIDTH_CAM-1:0] w_idx, w_limit, w_rd_addr;
  logic   w_ctr_load, w_ctr_inc, w_cmd_fire, w_in_fire, w_out_fire, w_dir_nxt;
  logic   [DATA_DEPTH-1:0]     w_row_ext;

  logic r_cmd_ready, r_in_ready, r_out_valid, r_busy, r_done, r_wr_n;
  logic [DATA_DEPTH-1:0]     r_out_data, r_ip_col;
  logic [DATA_WIDTH-1:0]     r_ip_row, r_cam_mask;
  logic [ADDR_WIDTH_CAM-1:0] r_ain_row, r_ain_col, r_aout_row, r_aout_col;
  logic [2:0]                r_mode;

  cam_addr_ctr #(.ADDR_WIDTH_CAM(ADDR_WIDTH_CAM)) u_idx_ctr (
    .clk       (clk),
    .rstIn     (rstIn),
    .i_load    (w_ctr_load),
    .i_load_val(bus.cmd_base),
    .i_inc     (w_ctr_inc),
    .i_limit   (w_limit),
    .o_idx     (w_idx)
  );

  assign w_cmd_fire = bus.cmd_valid & r_cmd_ready;
  assign w_in_fire  = bus.in_valid  & r_in_ready;
  assign w_out_fire = r_out_valid   & bus.out_ready;

  // Wrap limit, direction of the coming cycle, read address and row zero-extension.
  always_comb begin
    w_limit   = LIM_ROW;
    w_dir_nxt = r_dir;
    w_rd_addr = w_idx;
    w_row_ext = {DATA_DEPTH{1'b0}};
    w_row_ext[DATA_WIDTH-1:0] = cam_Q_out_row;
    if (r_dir == DIR_COL) begin
      w_limit = LIM_COL;
    end else begin
      w_limit = LIM_ROW;
    end
    if (w_cmd_fire) begin
      w_dir_nxt = bus.cmd_dir;
      w_rd_addr = bus.cmd_base;
    end else begin
      w_dir_nxt = r_dir;
      w_rd_addr = w_idx;
    end
  end

  // Next-state logic; the remaining-word count drops once per accepted/captured word.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_ctr_load  = 1'b0;
    w_ctr_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cmd_fire) begin
          w_ctr_load = 1'b1;
          w_rem_nxt  = bus.cmd_count;
          if (bus.cmd_count == ZERO_CNT) begin
            w_state_nxt = DONE;
          end else if (bus.cmd_op == OP_UNLOAD) begin
            w_state_nxt = RD_ADDR;
          end else begin
            w_state_nxt = LOAD;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LOAD: begin
        if (r_rem == ZERO_CNT) begin
          w_state_nxt = DONE;
        end else if (w_in_fire) begin
          w_ctr_inc = 1'b1;
          w_rem_nxt = r_rem - ONE_CNT;
        end else begin
          w_state_nxt = LOAD;
        end
      end
      RD_ADDR: w_state_nxt = RD_WAIT;
      RD_WAIT: w_state_nxt = RD_CAP;
      RD_CAP: begin
        w_state_nxt = OUT;
        w_ctr_inc   = 1'b1;
        w_rem_nxt   = r_rem - ONE_CNT;
      end
      OUT: begin
        if (w_out_fire) begin
          w_state_nxt = (r_rem != ZERO_CNT) ? RD_ADDR : DONE;
        end else begin
          w_state_nxt = OUT;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, latched command fields and handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rstIn) begin
      r_state     <= IDLE;
      r_rem       <= ZERO_CNT;
      r_op        <= OP_LOAD;
      r_dir       <= DIR_ROW;
      r_cmd_ready <= 1'b1;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wr_n      <= 1'b1;
      r_mode      <= MODE_NONE;
      r_cam_mask  <= {DATA_WIDTH{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_rem       <= w_rem_nxt;
      r_op        <= w_cmd_fire ? bus.cmd_op : r_op;
      r_dir       <= w_dir_nxt;
      r_cmd_ready <= (w_state_nxt == IDLE);
      r_in_ready  <= (w_state_nxt == LOAD) && (w_rem_nxt != ZERO_CNT);
      r_out_valid <= (w_state_nxt == OUT);
      r_busy      <= (w_state_nxt != IDLE);
      r_done      <= (w_state_nxt == DONE);
      r_wr_n      <= ~(w_in_fire && (r_op == OP_LOAD));
      r_mode      <= (w_state_nxt == IDLE) ? MODE_NONE : mode_for(w_dir_nxt, RowxRow, ColxCol);
      r_cam_mask  <= (w_state_nxt == IDLE) ? ext_Mask : {DATA_WIDTH{1'b0}};
    end
  end

  // Array write/read addresses and data; only the addressed orientation gets the index.
  always_ff @(posedge clk) begin
    if (rstIn) begin
      r_ip_row   <= {DATA_WIDTH{1'b0}};
      r_ip_col   <= {DATA_DEPTH{1'b0}};
      r_ain_row  <= ZERO_ADR;
      r_ain_col  <= ZERO_ADR;
      r_aout_row <= ZERO_ADR;
      r_aout_col <= ZERO_ADR;
      r_out_data <= {DATA_DEPTH{1'b0}};
    end else begin
      if (w_in_fire) begin
        r_ip_row  <= bus.in_data[DATA_WIDTH-1:0];
        r_ip_col  <= bus.in_data;
        r_ain_row <= (r_dir == DIR_ROW) ? w_idx : ZERO_ADR;
        r_ain_col <= (r_dir == DIR_COL) ? w_idx : ZERO_ADR;
      end else begin
        r_ip_row  <= r_ip_row;
        r_ip_col  <= r_ip_col;
        r_ain_row <= r_ain_row;
        r_ain_col <= r_ain_col;
      end
      if (w_state_nxt == RD_ADDR) begin
        r_aout_row <= (w_dir_nxt == DIR_ROW) ? w_rd_addr : ZERO_ADR;
        r_aout_col <= (w_dir_nxt == DIR_COL) ? w_rd_addr : ZERO_ADR;
      end else begin
        r_aout_row <= r_aout_row;
        r_aout_col <= r_aout_col;
      end
      if (r_state == RD_CAP) begin
        r_out_data <= (r_dir == DIR_COL) ? cam_Q_out_col : w_row_ext;
      end else begin
        r_out_data <= r_out_data;
      end
    end
  end

  assign bus.cmd_ready       = r_cmd_ready;
  assign bus.in_ready        = r_in_ready;
  assign bus.out_valid       = r_out_valid;
  assign bus.out_data        = r_out_data;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign cam_Mask            = r_cam_mask;
  assign cam_Ip_row          = r_ip_row;
  assign cam_Ip_col          = r_ip_col;
  assign cam_addr_input_Row  = r_ain_row;
  assign cam_addr_input_Col  = r_ain_col;
  assign cam_addr_output_Row = r_aout_row;
  assign cam_addr_output_Col = r_aout_col;
  assign cam_input_mode      = r_mode;
  assign cam_wr_n            = r_wr_n;
endmodule
